// File: rtl/p4_router_pkg.sv
// Shared types and constants for the P4 router egress shaper.
// Latency: n/a (types only); backpressure: n/a.
package p4_router_pkg;

    localparam int SHAPER_TOKEN_PAD   = 2;
    localparam int SHAPER_RATE_MAX_W  = 32;
    localparam int SHAPER_BURST_MAX_W = 32;

    // Held at the maximum widths; unused upper bits are constant zero and trim away.
    typedef struct packed {
        logic                          enable;
        logic [SHAPER_RATE_MAX_W-1:0]  rate;
        logic [SHAPER_BURST_MAX_W-1:0] burst;
    } shaper_cfg_t;

endpackage

// File: rtl/p4_router_token_bucket.sv
// One egress token bucket: config regs, saturating signed credit, registered eligibility.
// Latency: tokens and eligibility update at the edge of the event; backpressure: none.
module p4_router_token_bucket
    import p4_router_pkg::*;
#(
    parameter int RATE_W  = 16,
    parameter int BURST_W = 20,
    parameter int BYTES_W = 11
) (
    input  logic                                       clk,
    input  logic                                       aresetn,
    input  logic                                       tick_i,
    input  logic                                       cfg_wr_i,
    input  logic                                       cfg_enable_i,
    input  logic [RATE_W-1:0]                          cfg_rate_i,
    input  logic [BURST_W-1:0]                         cfg_burst_i,
    input  logic                                       debit_vld_i,
    input  logic [BYTES_W-1:0]                         debit_bytes_i,
    output logic signed [BURST_W+SHAPER_TOKEN_PAD-1:0] tokens_o,
    output logic                                       eligible_o
);

    localparam int TOKEN_W = BURST_W + SHAPER_TOKEN_PAD;
    localparam int WIDE_W  = (SHAPER_BURST_MAX_W > SHAPER_RATE_MAX_W) ? SHAPER_BURST_MAX_W
                                                                       : SHAPER_RATE_MAX_W;
    localparam int SUM_W   = ((TOKEN_W > WIDE_W + 1) ? TOKEN_W : WIDE_W + 1) + 2;

    localparam logic signed [SUM_W-1:0] TOK_MIN =
        {{(SUM_W - TOKEN_W + 1){1'b1}}, {(TOKEN_W - 1){1'b0}}};

    shaper_cfg_t               cfg_q, cfg_d;
    logic signed [TOKEN_W-1:0] tokens_q, tokens_d;
    logic                      elig_q, elig_d;

    logic signed [SUM_W-1:0]   tok_sum;
    logic signed [SUM_W-1:0]   tok_sat;
    logic signed [SUM_W-1:0]   burst_ext;

    always_comb begin
        burst_ext = SUM_W'($signed({1'b0, cfg_q.burst}));

        tok_sum = SUM_W'(tokens_q);
        if (tick_i) begin
            tok_sum = tok_sum + SUM_W'($signed({1'b0, cfg_q.rate}));
        end
        if (debit_vld_i) begin
            tok_sum = tok_sum - SUM_W'($signed({1'b0, debit_bytes_i}));
        end

        if (tok_sum > burst_ext) begin
            tok_sat = burst_ext;
        end else if (tok_sum < TOK_MIN) begin
            tok_sat = TOK_MIN;
        end else begin
            tok_sat = tok_sum;
        end

        // A config write refills to the new ceiling and swallows any same-cycle tick or debit.
        cfg_d    = cfg_q;
        tokens_d = TOKEN_W'(tok_sat);
        if (cfg_wr_i) begin
            cfg_d.enable = cfg_enable_i;
            cfg_d.rate   = SHAPER_RATE_MAX_W'(cfg_rate_i);
            cfg_d.burst  = SHAPER_BURST_MAX_W'(cfg_burst_i);
            tokens_d     = TOKEN_W'(cfg_burst_i);
        end else if (!cfg_q.enable) begin
            tokens_d = TOKEN_W'(cfg_q.burst);
        end

        elig_d = !cfg_d.enable || (tokens_d > 0);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cfg_q    <= '0;
            tokens_q <= '0;
            elig_q   <= 1'b0;
        end else begin
            cfg_q    <= cfg_d;
            tokens_q <= tokens_d;
            elig_q   <= elig_d;
        end
    end

    assign tokens_o   = tokens_q;
    assign eligible_o = elig_q;

endmodule

// File: rtl/p4_router_egr_shaper.sv
// Per-egress-port token-bucket shaper producing a registered scheduler eligibility vector.
// Latency: events land at their own edge, readback lags one cycle; backpressure: none.
module p4_router_egr_shaper
    import p4_router_pkg::*;
#(
    parameter int  NUM_EGR_PORTS = 1,
    parameter int  MTU_BYTES     = 2000,
    parameter int  REFILL_PERIOD = 256,
    parameter int  RATE_W        = 16,
    parameter int  BURST_W       = 20,
    localparam int PORT_W        = (NUM_EGR_PORTS > 1) ? $clog2(NUM_EGR_PORTS) : 1,
    localparam int BYTES_W       = $clog2(MTU_BYTES + 1),
    localparam int TOKEN_W       = BURST_W + SHAPER_TOKEN_PAD
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic                      pkt_done_valid,
    input  logic [PORT_W-1:0]         pkt_done_port,
    input  logic [BYTES_W-1:0]        pkt_done_bytes,
    input  logic                      cfg_wr,
    input  logic [PORT_W-1:0]         cfg_port,
    input  logic                      cfg_enable,
    input  logic [RATE_W-1:0]         cfg_rate,
    input  logic [BURST_W-1:0]        cfg_burst,
    output logic signed [TOKEN_W-1:0] cfg_rd_tokens,
    output logic [NUM_EGR_PORTS-1:0]  egr_port_eligible
);

    localparam int CNT_W = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;

    if (BYTES_W > BURST_W) begin : g_chk_mtu
        $error("MTU_BYTES does not fit in a BURST_W-wide bucket");
    end
    if (REFILL_PERIOD < 2) begin : g_chk_period
        $error("REFILL_PERIOD must be at least 2");
    end
    if (RATE_W > SHAPER_RATE_MAX_W || BURST_W > SHAPER_BURST_MAX_W) begin : g_chk_widths
        $error("RATE_W or BURST_W exceeds the shaper_cfg_t field width");
    end

    logic [CNT_W-1:0] presc_q, presc_d;
    logic             tick;

    assign tick = (presc_q == CNT_W'(REFILL_PERIOD - 1));

    always_comb begin
        presc_d = tick ? '0 : presc_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    logic signed [TOKEN_W-1:0] bkt_tokens [NUM_EGR_PORTS];

    // Out-of-range port indices match no bucket, so they fall through as no-ops.
    for (genvar p = 0; p < NUM_EGR_PORTS; p++) begin : g_bkt
        logic hit_cfg;
        logic hit_debit;

        assign hit_cfg   = cfg_wr && (cfg_port == PORT_W'(p));
        assign hit_debit = pkt_done_valid && (pkt_done_port == PORT_W'(p));

        p4_router_token_bucket #(
            .RATE_W  (RATE_W),
            .BURST_W (BURST_W),
            .BYTES_W (BYTES_W)
        ) u_bkt (
            .clk           (clk),
            .aresetn       (aresetn),
            .tick_i        (tick),
            .cfg_wr_i      (hit_cfg),
            .cfg_enable_i  (cfg_enable),
            .cfg_rate_i    (cfg_rate),
            .cfg_burst_i   (cfg_burst),
            .debit_vld_i   (hit_debit),
            .debit_bytes_i (pkt_done_bytes),
            .tokens_o      (bkt_tokens[p]),
            .eligible_o    (egr_port_eligible[p])
        );
    end

    logic signed [TOKEN_W-1:0] rd_q, rd_d;

    always_comb begin
        rd_d = '0;
        for (int i = 0; i < NUM_EGR_PORTS; i++) begin
            if (cfg_port == PORT_W'(i)) begin
                rd_d = bkt_tokens[i];
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign cfg_rd_tokens = rd_q;

endmodule

// File: tb/tb_p4_router_egr_shaper.sv
// Directed vector table plus random traffic against a per-port bucket model.
// Latency: n/a (bench); backpressure: n/a.
module tb_p4_router_egr_shaper;

    localparam int     N       = 5;
    localparam int     P       = 16;
    localparam int     MTU     = 2000;
    localparam int     RATE_W  = 16;
    localparam int     BURST_W = 20;
    localparam int     TOKEN_W = BURST_W + 2;
    localparam longint TMIN    = -(longint'(1) << (TOKEN_W - 1));

    logic                      clk = 1'b0;
    logic                      aresetn;
    logic                      pkt_done_valid;
    logic [2:0]                pkt_done_port;
    logic [10:0]               pkt_done_bytes;
    logic                      cfg_wr;
    logic [2:0]                cfg_port;
    logic                      cfg_enable;
    logic [RATE_W-1:0]         cfg_rate;
    logic [BURST_W-1:0]        cfg_burst;
    logic signed [TOKEN_W-1:0] cfg_rd_tokens;
    logic [N-1:0]              egr_port_eligible;

    p4_router_egr_shaper #(
        .NUM_EGR_PORTS (N),
        .MTU_BYTES     (MTU),
        .REFILL_PERIOD (P),
        .RATE_W        (RATE_W),
        .BURST_W       (BURST_W)
    ) dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .pkt_done_valid    (pkt_done_valid),
        .pkt_done_port     (pkt_done_port),
        .pkt_done_bytes    (pkt_done_bytes),
        .cfg_wr            (cfg_wr),
        .cfg_port          (cfg_port),
        .cfg_enable        (cfg_enable),
        .cfg_rate          (cfg_rate),
        .cfg_burst         (cfg_burst),
        .cfg_rd_tokens     (cfg_rd_tokens),
        .egr_port_eligible (egr_port_eligible)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // Reference model: one record per bucket, edges counted since reset release.
    bit           m_en    [N];
    longint       m_rate  [N];
    longint       m_burst [N];
    longint       m_tok   [N];
    logic [N-1:0] m_elig;
    longint       m_rd;
    int           edge_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        bit           wr;
        logic [2:0]   wport;
        bit           en;
        int           rate;
        int           burst;
        bit           dv;
        logic [2:0]   dport;
        int           dbytes;
        bit           tick;
        logic [2:0]   rport;
        longint       exp_tok;
        logic [N-1:0] exp_elig;
        int           seq;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < N; p++) begin
            m_en[p]    = 1'b0;
            m_rate[p]  = 0;
            m_burst[p] = 0;
            m_tok[p]   = 0;
        end
        m_elig   = '0;
        m_rd     = 0;
        edge_cnt = 0;
    endtask

    task automatic model_step();
        bit     tick;
        longint t;
        edge_cnt++;
        tick = (edge_cnt % P) == 0;
        m_rd = (int'(cfg_port) < N) ? m_tok[cfg_port] : 0;
        for (int p = 0; p < N; p++) begin
            if (cfg_wr && int'(cfg_port) == p) begin
                m_en[p]    = cfg_enable;
                m_rate[p]  = cfg_rate;
                m_burst[p] = cfg_burst;
                m_tok[p]   = cfg_burst;
            end else if (!m_en[p]) begin
                m_tok[p] = m_burst[p];
            end else begin
                t = m_tok[p];
                if (tick) t += m_rate[p];
                if (pkt_done_valid && int'(pkt_done_port) == p) t -= pkt_done_bytes;
                if (t > m_burst[p]) t = m_burst[p];
                if (t < TMIN) t = TMIN;
                m_tok[p] = t;
            end
            m_elig[p] = !m_en[p] || (m_tok[p] > 0);
        end
    endtask

    function automatic bit tick_at(input int k);
        return ((edge_cnt + k) % P) == 0;
    endfunction

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("elig", egr_port_eligible, m_elig);
        check("rd_tokens", cfg_rd_tokens, m_rd);
    endtask

    task automatic idle();
        cfg_wr         = 1'b0;
        pkt_done_valid = 1'b0;
    endtask

    function automatic vec_t mkv(input string name, input bit wr, input int wport, input bit en,
                                 input int rate, input int burst, input bit dv, input int dport,
                                 input int dbytes, input bit tick, input int rport,
                                 input longint tok, input logic [N-1:0] elig, input int seq);
        vec_t v;
        v.name = name;   v.wr = wr;             v.wport = 3'(wport);   v.en = en;
        v.rate = rate;   v.burst = burst;       v.dv = dv;             v.dport = 3'(dport);
        v.dbytes = dbytes; v.tick = tick;       v.rport = 3'(rport);   v.exp_tok = tok;
        v.exp_elig = elig; v.seq = seq;
        return v;
    endfunction

    task automatic run_seq(input int seq);
        int bad;
        case (seq)
            1: begin
                for (int i = 1; i <= 6; i++) begin
                    while (!tick_at(1)) step();
                    cfg_port = 3'd1;
                    step();
                    check($sformatf("refill_p1_tick%0d_elig", i), egr_port_eligible[1], (i == 6));
                end
                step();
                check("refill_p1_tokens", cfg_rd_tokens, 100);
            end
            2: begin
                bad = 0;
                for (int i = 0; i < 1000; i++) begin
                    step();
                    if (egr_port_eligible[3] !== 1'b0) bad++;
                end
                check("pause_p3_hold_cycles_eligible", bad, 0);
            end
            3: begin
                cfg_port = 3'd4;
                for (int i = 1; i <= 10; i++) begin
                    while (!tick_at(1)) step();
                    step();
                    step();
                    check($sformatf("sat_p4_tick%0d", i), cfg_rd_tokens,
                          (300 * i > 1000) ? 1000 : 300 * i);
                end
            end
            default: ;
        endcase
    endtask

    task automatic apply_vec(input vec_t v);
        idle();
        if (v.tick) begin
            while (!tick_at(1)) step();
        end else begin
            while (tick_at(1) || tick_at(2)) step();
        end
        cfg_wr         = v.wr;
        cfg_port       = v.wport;
        cfg_enable     = v.en;
        cfg_rate       = RATE_W'(v.rate);
        cfg_burst      = BURST_W'(v.burst);
        pkt_done_valid = v.dv;
        pkt_done_port  = v.dport;
        pkt_done_bytes = 11'(v.dbytes);
        step();
        check({v.name, "_elig"}, egr_port_eligible, v.exp_elig);
        idle();
        cfg_port = v.rport;
        step();
        check({v.name, "_tokens"}, cfg_rd_tokens, v.exp_tok);
    endtask

    initial begin
        aresetn        = 1'b0;
        pkt_done_valid = 1'b0;
        pkt_done_port  = '0;
        pkt_done_bytes = '0;
        cfg_wr         = 1'b0;
        cfg_port       = '0;
        cfg_enable     = 1'b0;
        cfg_rate       = '0;
        cfg_burst      = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_elig", egr_port_eligible, 0);
        check("reset_rd_tokens", cfg_rd_tokens, 0);
        aresetn = 1'b1;
        step();
        check("release_elig_all_ones", egr_port_eligible, 5'b11111);
        check("release_rd_tokens", cfg_rd_tokens, 0);

        //              name                wr wp en rate  burst dv dp bytes tk rp   tok   elig     seq
        vecs.push_back(mkv("cfg_p1",          1, 1, 1, 100, 1000, 0, 0,    0, 0, 1, 1000, 5'b11111, 0));
        vecs.push_back(mkv("debit_p1_1500",   0, 0, 0,   0,    0, 1, 1, 1500, 0, 1, -500, 5'b11101, 1));
        vecs.push_back(mkv("cfg_p2",          1, 2, 1, 100, 1000, 0, 0,    0, 0, 2, 1000, 5'b11111, 0));
        vecs.push_back(mkv("debit_p2_500",    0, 0, 0,   0,    0, 1, 2,  500, 0, 2,  500, 5'b11111, 0));
        vecs.push_back(mkv("tick_debit_p2",   0, 0, 0,   0,    0, 1, 2,   64, 1, 2,  536, 5'b11111, 0));
        vecs.push_back(mkv("cfg_vs_debit_p0", 1, 0, 1,  50,  800, 1, 0, 2000, 0, 0,  800, 5'b11111, 0));
        vecs.push_back(mkv("cfg_oor_p7",      1, 7, 1,   5,    5, 0, 0,    0, 0, 7,    0, 5'b11111, 0));
        vecs.push_back(mkv("debit_oor_p6",    0, 0, 0,   0,    0, 1, 6, 1000, 0, 0,  800, 5'b11111, 0));
        vecs.push_back(mkv("cfg_p3_pause",    1, 3, 1,   0,  100, 0, 0,    0, 0, 3,  100, 5'b11111, 0));
        vecs.push_back(mkv("debit_p3_100",    0, 0, 0,   0,    0, 1, 3,  100, 0, 3,    0, 5'b10111, 2));
        vecs.push_back(mkv("disable_p3",      1, 3, 0,   0,  100, 0, 0,    0, 0, 3,  100, 5'b11111, 0));
        vecs.push_back(mkv("cfg_p4",          1, 4, 1, 300, 1000, 0, 0,    0, 0, 4, 1000, 5'b11111, 0));
        vecs.push_back(mkv("debit_p4_1000",   0, 0, 0,   0,    0, 1, 4, 1000, 0, 4,    0, 5'b01111, 3));

        foreach (vecs[i]) begin
            apply_vec(vecs[i]);
            run_seq(vecs[i].seq);
        end

        // Drive one bucket into the negative floor with back-to-back MTU debits.
        idle();
        cfg_wr     = 1'b1;
        cfg_port   = 3'd0;
        cfg_enable = 1'b1;
        cfg_rate   = '0;
        cfg_burst  = '0;
        step();
        idle();
        pkt_done_valid = 1'b1;
        pkt_done_port  = 3'd0;
        pkt_done_bytes = 11'(MTU);
        for (int i = 0; i < 1100; i++) step();
        idle();
        step();
        check("lower_clamp_tokens", cfg_rd_tokens, TMIN);
        check("lower_clamp_elig", egr_port_eligible[0], 0);

        for (int c = 0; c < 3000; c++) begin
            cfg_wr         = ($urandom_range(0, 7) == 0);
            cfg_port       = 3'($urandom_range(0, 7));
            cfg_enable     = ($urandom_range(0, 3) != 0);
            cfg_rate       = ($urandom_range(0, 9) == 0) ? RATE_W'($urandom)
                                                         : RATE_W'($urandom_range(0, 600));
            cfg_burst      = ($urandom_range(0, 9) == 0) ? BURST_W'($urandom)
                                                         : BURST_W'($urandom_range(0, 3000));
            pkt_done_valid = 1'($urandom_range(0, 1));
            pkt_done_port  = 3'($urandom_range(0, 7));
            pkt_done_bytes = 11'($urandom_range(0, MTU));
            step();
        end

        // Asynchronous reset in the middle of traffic.
        aresetn = 1'b0;
        #1;
        check("midreset_async_elig", egr_port_eligible, 0);
        check("midreset_async_rd", cfg_rd_tokens, 0);
        @(posedge clk);
        #1;
        check("midreset_held_elig", egr_port_eligible, 0);
        idle();
        cfg_port = 3'd0;
        aresetn  = 1'b1;
        model_reset();
        step();
        check("midreset_release_elig", egr_port_eligible, 5'b11111);
        step();
        check("midreset_release_tokens", cfg_rd_tokens, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
